// File: rtl/mem_arb_interface_if.sv
// Bus between mem_arb_interface and its per-channel request/response FIFOs.
// master: arbiter side, slave: FIFO side.
interface mem_arb_interface_if #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 31,
  parameter int TID_WIDTH  = 16
);
  localparam int REQ_WIDTH      = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int DP_DATA_WIDTH  = TID_WIDTH + REQ_WIDTH;
  localparam int VPI_DATA_WIDTH = TID_WIDTH + DATA_WIDTH;

  logic [CHANNELS-1:0]                read_ctr_pack;
  logic [DP_DATA_WIDTH*CHANNELS-1:0]  data_in_pack;
  logic [CHANNELS-1:0]                empty_flag_pack;
  logic [CHANNELS-1:0]                write_ctr_pack;
  logic [VPI_DATA_WIDTH*CHANNELS-1:0] data_out_pack;
  logic [CHANNELS-1:0]                full_flag_pack;
  logic [16*CHANNELS-1:0]             stat_count_pack;

  modport master (
    output read_ctr_pack,
    input  data_in_pack,
    input  empty_flag_pack,
    output write_ctr_pack,
    output data_out_pack,
    input  full_flag_pack,
    output stat_count_pack
  );

  modport slave (
    input  read_ctr_pack,
    output data_in_pack,
    output empty_flag_pack,
    input  write_ctr_pack,
    input  data_out_pack,
    output full_flag_pack,
    input  stat_count_pack
  );
endinterface

// File: rtl/mem_arb_interface.sv
// Round-robin arbiter giving CHANNELS FIFO pairs access to one shared memory.
// Define MEM_IF_STATS_EN to build per-channel serviced-request counters.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | pick next eligible channel round-robin from last_grant+1
// ST_FETCH   | pop strobe to the granted request FIFO
// ST_ACCESS  | capture popped request, write or read shared memory
// ST_RESPOND | push {tid, data} once the response FIFO has room
module mem_arb_interface #(
  parameter int CHANNELS       = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 31,
  parameter int TID_WIDTH      = 16,
  parameter int MEM_DEPTH_LOG2 = 8
) (
  input logic                 clk,
  input logic                 reset,
  mem_arb_interface_if.master bus
);
  localparam int REQ_WIDTH      = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int DP_DATA_WIDTH  = TID_WIDTH + REQ_WIDTH;
  localparam int VPI_DATA_WIDTH = TID_WIDTH + DATA_WIDTH;
  localparam int GW             = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int MEM_WORDS      = 2 ** MEM_DEPTH_LOG2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_ACCESS  = 2'd2;
  localparam logic [1:0] ST_RESPOND = 2'd3;

  logic [1:0]                         state;
  logic [GW-1:0]                      grant;
  logic [GW-1:0]                      last_grant;
  logic [GW-1:0]                      next_grant;
  logic [GW-1:0]                      idx;
  logic                               grant_ok;
  logic [CHANNELS-1:0]                eligible;
  logic [CHANNELS-1:0]                read_ctr;
  logic [CHANNELS-1:0]                write_ctr;
  logic [VPI_DATA_WIDTH*CHANNELS-1:0] data_out;
  logic [TID_WIDTH-1:0]               tid_q;
  logic [DATA_WIDTH-1:0]              resp_q;
  logic [DATA_WIDTH-1:0]              mem [MEM_WORDS];

  logic [DP_DATA_WIDTH-1:0]           req_word;
  logic [TID_WIDTH-1:0]               req_tid;
  logic                               req_rw;
  logic [ADDR_WIDTH-1:0]              req_addr;
  logic [DATA_WIDTH-1:0]              req_data;
  logic [MEM_DEPTH_LOG2-1:0]          mem_idx;
  logic                               unused_addr;

  assign eligible = ~bus.empty_flag_pack & ~bus.full_flag_pack;

  // Scan downward so the closest eligible channel after last_grant wins.
  always_comb begin
    next_grant = last_grant;
    grant_ok   = 1'b0;
    idx        = '0;
    for (int i = CHANNELS; i >= 1; i--) begin
      idx = GW'((int'(last_grant) + i) % CHANNELS);
      if (eligible[idx]) begin
        next_grant = idx;
        grant_ok   = 1'b1;
      end
    end
  end

  assign req_word = bus.data_in_pack[int'(grant)*DP_DATA_WIDTH +: DP_DATA_WIDTH];
  assign {req_tid, req_rw, req_addr, req_data} = req_word;
  assign mem_idx     = req_addr[MEM_DEPTH_LOG2-1:0];
  assign unused_addr = ^req_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= GW'(CHANNELS - 1);
      read_ctr   <= '0;
      write_ctr  <= '0;
      data_out   <= '0;
      tid_q      <= '0;
      resp_q     <= '0;
    end else begin
      read_ctr  <= '0;
      write_ctr <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_ok) begin
            grant              <= next_grant;
            read_ctr[next_grant] <= 1'b1;
            state              <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_ACCESS;
        ST_ACCESS: begin
          tid_q  <= req_tid;
          resp_q <= req_rw ? req_data : mem[mem_idx];
          state  <= ST_RESPOND;
        end
        ST_RESPOND: begin
          if (!bus.full_flag_pack[grant]) begin
            write_ctr[grant] <= 1'b1;
            data_out[int'(grant)*VPI_DATA_WIDTH +: VPI_DATA_WIDTH] <= {tid_q, resp_q};
            last_grant <= grant;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory is never cleared; a reset during ACCESS suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && state == ST_ACCESS && req_rw)
      mem[mem_idx] <= req_data;
  end

  assign bus.read_ctr_pack  = read_ctr;
  assign bus.write_ctr_pack = write_ctr;
  assign bus.data_out_pack  = data_out;

`ifdef MEM_IF_STATS_EN
  logic [15:0] stat_count [CHANNELS];

  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (reset)
        stat_count[c] <= '0;
      else if (write_ctr[c] && stat_count[c] != 16'hFFFF)
        stat_count[c] <= stat_count[c] + 16'd1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_stat
    assign bus.stat_count_pack[c*16 +: 16] = stat_count[c];
  end
`else
  assign bus.stat_count_pack = '0;
`endif
endmodule
